// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory-port arbiter: FSM states, owner encoding
// and grant-vector bit positions.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } arb_owner_e;

    localparam int GNT_I = 0;
    localparam int GNT_D = 1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the upstream I/D request ports and the downstream simple memory
// port seen by mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Upstream: req + payload are held until the one-cycle gnt; valid is a
    // one-cycle completion pulse. Downstream: a request transfers on the cycle
    // dn_req && dn_ready, and completes with a one-cycle dn_valid pulse.
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_gnt;
    logic                  i_valid;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_gnt;
    logic                  d_valid;
    logic [DATA_W-1:0]     d_rdata;

    logic [ADDR_W-1:0]     dn_addr;
    logic [DATA_W-1:0]     dn_wdata;
    logic [DATA_W/8-1:0]   dn_wstrb;
    logic                  dn_req;
    logic                  dn_we;
    logic                  dn_ready;
    logic                  dn_valid;
    logic [DATA_W-1:0]     dn_rdata;

    logic                  busy;
    logic                  owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  dn_ready, dn_valid, dn_rdata,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        output dn_addr, dn_wdata, dn_wstrb, dn_req, dn_we, busy, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
        output dn_ready, dn_valid, dn_rdata,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        input  dn_addr, dn_wdata, dn_wstrb, dn_req, dn_we, busy, owner
    );

endinterface

// File: rtl/mem_port_arbiter_sel.sv
// mem_arb_sel: combinational two-way picker. Fixed D-over-I on a tie unless
// rr_en_i, in which case the port not granted last wins the tie.
module mem_arb_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  arb_owner_e last_i,
    input  logic       rr_en_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (i_req_i && d_req_i) begin
            if (rr_en_i && (last_i == ARB_OWN_D)) begin
                gnt_o[GNT_I] = 1'b1;
            end else begin
                gnt_o[GNT_D] = 1'b1;
            end
        end else if (d_req_i) begin
            gnt_o[GNT_D] = 1'b1;
        end else if (i_req_i) begin
            gnt_o[GNT_I] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one simple memory port between instruction fetch (I) and load/store (D),
// one transaction at a time. Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus,
    output arb_state_e         dbg_state_o
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                we_q;

    logic [1:0]          pick;
    logic                take;
    arb_owner_e          last_grant;
    logic                rr_en;

`ifdef MEM_ARB_RR_EN
    arb_owner_e last_q;

    assign rr_en      = 1'b1;
    assign last_grant = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= ARB_OWN_I;
        end else if (take) begin
            last_q <= pick[GNT_D] ? ARB_OWN_D : ARB_OWN_I;
        end
    end
`else
    assign rr_en      = 1'b0;
    assign last_grant = ARB_OWN_I;
`endif

    mem_arb_sel u_sel (
        .i_req_i (bus.i_req),
        .d_req_i (bus.d_req),
        .last_i  (last_grant),
        .rr_en_i (rr_en),
        .gnt_o   (pick)
    );

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        state_d     = state_q;
        take        = 1'b0;
        bus.i_gnt   = 1'b0;
        bus.d_gnt   = 1'b0;
        bus.dn_req  = 1'b0;
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (rst_n && (pick != 2'b00)) begin
                    take      = 1'b1;
                    bus.i_gnt = pick[GNT_I];
                    bus.d_gnt = pick[GNT_D];
                    state_d   = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus.dn_req = 1'b1;
                if (bus.dn_ready) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (bus.dn_valid) state_d = ARB_RESP;
            end
            ARB_RESP: begin
                bus.i_valid = (owner_q == ARB_OWN_I);
                bus.d_valid = (owner_q == ARB_OWN_D);
                state_d     = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWN_I;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                if (pick[GNT_D]) begin
                    owner_q <= ARB_OWN_D;
                    addr_q  <= bus.d_addr;
                    wdata_q <= bus.d_wdata;
                    wstrb_q <= bus.d_wstrb;
                    we_q    <= bus.d_we;
                end else begin
                    // Instruction fetches are always plain reads.
                    owner_q <= ARB_OWN_I;
                    addr_q  <= bus.i_addr;
                    wdata_q <= '0;
                    wstrb_q <= '0;
                    we_q    <= 1'b0;
                end
            end
        end
    end

    assign bus.dn_addr  = addr_q;
    assign bus.dn_wdata = wdata_q;
    assign bus.dn_wstrb = wstrb_q;
    assign bus.dn_we    = we_q;
    assign bus.busy     = (state_q != ARB_IDLE);
    assign bus.owner    = owner_q;
    assign bus.i_rdata  = bus.dn_rdata;
    assign bus.d_rdata  = bus.dn_rdata;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing the CPU's single simple memory port between the instruction-fetch (I) port and the load/store (D) port.
- Sits between the core and the AXI4-Lite master's simple memory interface (the dn_* side).
- Allows one outstanding transaction at a time. Latches the winner's request, issues it downstream, waits for completion, then returns a one-cycle response to the owner.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_req  input  1  I-port request (read-only); held with i_addr until i_gnt
- i_addr  input  ADDR_W  I-port address
- i_gnt  output  1  I-port request accepted (1-cycle pulse)
- i_valid  output  1  I-port read complete (1-cycle pulse)
- i_rdata  output  DATA_W  I-port read data, meaningful only while i_valid
- d_req  input  1  D-port request; held with payload until d_gnt
- d_we  input  1  D-port write enable
- d_addr  input  ADDR_W  D-port address
- d_wdata  input  DATA_W  D-port write data
- d_wstrb  input  DATA_W/8  D-port byte strobes
- d_gnt  output  1  D-port request accepted (1-cycle pulse)
- d_valid  output  1  D-port transaction complete, read or write (1-cycle pulse)
- d_rdata  output  DATA_W  D-port read data, meaningful only while d_valid and the transaction was a read
- dn_addr, dn_wdata, dn_wstrb  output  ADDR_W/DATA_W/DATA_W/8  latched payload to the downstream port
- dn_req  output  1  downstream request
- dn_we  output  1  downstream write enable
- dn_ready  input  1  downstream can accept; a request transfers when dn_req && dn_ready
- dn_valid  input  1  downstream completion pulse
- dn_rdata  input  DATA_W  downstream read data, stable from the cycle after dn_valid
- busy  output  1  high in any state other than IDLE
- owner  output  1  0 = I, 1 = D; the latched owner of the current transaction

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset: state IDLE, owner 0, last-grant register = I. All outputs are 0: gnt, valid, dn_req, dn_we, busy, owner, dn_addr, dn_wdata, dn_wstrb. rdata follows dn_rdata.
- IDLE:
  - If any req is high, i_gnt or d_gnt is asserted combinationally for the winner in this cycle.
  - On that edge, latch addr/wdata/wstrb/we and owner, and go to ISSUE.
  - An I request always latches we=0 and wstrb=0.
  - If no req is high, stay in IDLE.
- Arbitration (default): if both requests are high, D wins (fixed priority).
- ISSUE:
  - dn_req=1; dn_we and payload come from the latch and are held stable.
  - If dn_ready, go to WAIT; otherwise stay.
- WAIT:
  - dn_req=0.
  - On dn_valid, go to RESP. A dn_valid in the same cycle as entry is not possible, since the downstream needs at least one cycle.
- RESP:
  - Owner's valid=1 for exactly one cycle; that port's rdata = dn_rdata.
  - The other port's valid=0.
  - Always go to IDLE next. No grant is issued in RESP.
- Minimum latency with zero-wait downstream: gnt in cycle 0, dn_req in cycle 1, valid in the cycle after dn_valid.
- A requester may re-raise req immediately after gnt. It waits in IDLE arbitration and is never granted while busy.
- dn_valid seen outside WAIT is ignored. No state change and no upstream valid.
- rst_n asserted mid-transaction: immediate return to IDLE with reset outputs. The in-flight transaction is dropped with no upstream valid. The downstream shares rst_n.
- Simultaneous req from both ports in IDLE with RR off: D granted. I is granted on the next IDLE cycle if d_req is then low.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: on a tie, grant the port not granted last. The last-grant register updates on every grant and resets to I, so D wins the first tie. Alternates I/D under continuous contention.
- Undefined: fixed D-over-I priority; the last-grant register is absent.

Decomposition:
- rv32i_pkg gets:
  - typedef enum arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP};
  - typedef enum logic arb_owner_e {ARB_OWN_I=0, ARB_OWN_D=1}.
- One sub-module, mem_arb_sel: combinational 2-way picker with inputs i_req, d_req, last, and rr_en, producing a grant vector. The RR register stays in the parent.

Test Plan:
- I only: i_req=1, i_addr=0x100, downstream returns 0xDEADBEEF -> i_gnt in cycle 0; dn_req with dn_addr=0x100 and dn_we=0; i_valid exactly 1 cycle with i_rdata=0xDEADBEEF; d_valid stays 0.
- D write: d_we=1, addr 0x2000_0004, wdata 0x12345678, wstrb 0xF -> dn_we=1 with payload identical and held while dn_ready=0 for 3 cycles; d_valid pulse the cycle after dn_valid.
- Tie, RR off: both req in the same cycle -> d_gnt first; i_gnt in the first IDLE after the D RESP once d_req drops; 10 back-to-back D requests starve I, and I gets no grant.
- Tie, MEM_ARB_RR_EN: both held high for 4 transactions -> grant order D, I, D, I.
- Reset mid-WAIT: assert rst_n low during WAIT -> all outputs 0 and busy=0 in the same cycle; after release, a spurious dn_valid produces no upstream valid.
- Back-to-back: D request again the cycle after d_gnt -> second d_gnt only in the IDLE following RESP; never two outstanding dn_req transfers.
